// File: rtl/wide2narrow_stream_if.sv
// Handshake bundle for the wide-to-narrow converter: wide input side (s_*) and narrow output side (m_*).
// The converter is the slave, the surrounding environment is the master.
interface wide2narrow_stream_if #(
  parameter int NARROW_W = 4,
  parameter int RATIO    = 2
);
  localparam int WIDE_W = NARROW_W * RATIO;
  localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic                s_valid;
  logic                s_ready;
  logic [WIDE_W-1:0]   s_data;
  logic [CNT_W-1:0]    s_cnt;
  logic                m_valid;
  logic                m_ready;
  logic [NARROW_W-1:0] m_data;
  logic                m_first;
  logic                m_last;

  modport master (
    output s_valid, s_data, s_cnt, m_ready,
    input  s_ready, m_valid, m_data, m_first, m_last
  );

  modport slave (
    input  s_valid, s_data, s_cnt, m_ready,
    output s_ready, m_valid, m_data, m_first, m_last
  );
endinterface

// File: rtl/wide2narrow_stream.sv
// Wide-to-narrow stream converter: holds one wide word and emits its first s_cnt+1 slices,
// MSB-first or LSB-first, with a registered narrow output and no bubble between words.
module wide2narrow_stream #(
  parameter int NARROW_W  = 4,
  parameter int RATIO     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wide2narrow_stream_if.slave  bus
);
  localparam int WIDE_W = NARROW_W * RATIO;
  localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] FIRST_IDX = MSB_FIRST ? MAX_CNT : '0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [WIDE_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                m_valid_q, m_valid_d;
  logic [NARROW_W-1:0] m_data_q, m_data_d;
  logic                m_first_q, m_first_d;
  logic                m_last_q, m_last_d;

  logic                s_ready;
  logic                load;
  logic [CNT_W-1:0]    cnt_eff;
  logic [CNT_W-1:0]    idx_nxt;
  logic [NARROW_W-1:0] load_slice;
  logic [NARROW_W-1:0] next_slice;

  assign idx_nxt = MSB_FIRST ? idx_q - CNT_W'(1) : idx_q + CNT_W'(1);

  // Only a non-power-of-two RATIO can see an out-of-range count on the s_cnt bus.
  generate
    if (RATIO == 1) begin : g_cnt_r1
      assign cnt_eff = '0;
    end else if ((1 << CNT_W) > RATIO) begin : g_cnt_clamp
      assign cnt_eff = (bus.s_cnt > MAX_CNT) ? MAX_CNT : bus.s_cnt;
    end else begin : g_cnt_pass
      assign cnt_eff = bus.s_cnt;
    end
  endgenerate

  generate
    if (RATIO == 1) begin : g_sel_r1
      assign load_slice = bus.s_data;
      assign next_slice = hold_q;
    end else begin : g_sel_rn
      logic [RATIO-1:0][NARROW_W-1:0] s_slices;
      logic [RATIO-1:0][NARROW_W-1:0] hold_slices;
      assign s_slices    = bus.s_data;
      assign hold_slices = hold_q;
      assign load_slice  = s_slices[FIRST_IDX];
      assign next_slice  = hold_slices[idx_nxt];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_first_d = m_first_q;
    m_last_d  = m_last_q;

    // Accepting while the last slice drains lets the next word follow with no idle cycle.
    s_ready = (state_q == ST_IDLE) ||
              ((state_q == ST_SEND) && m_valid_q && bus.m_ready && m_last_q);
    load    = bus.s_valid && s_ready;

    if (load) begin
      state_d   = ST_SEND;
      hold_d    = bus.s_data;
      idx_d     = FIRST_IDX;
      rem_d     = cnt_eff;
      m_valid_d = 1'b1;
      m_data_d  = load_slice;
      m_first_d = 1'b1;
      m_last_d  = (cnt_eff == '0);
    end else if ((state_q == ST_SEND) && bus.m_ready) begin
      if (rem_q != '0) begin
        idx_d     = idx_nxt;
        rem_d     = rem_q - CNT_W'(1);
        m_data_d  = next_slice;
        m_first_d = 1'b0;
        m_last_d  = (rem_q == CNT_W'(1));
      end else begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
        m_first_d = 1'b0;
        m_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_first = m_first_q;
  assign bus.m_last  = m_last_q;
endmodule

// File: tb/tb_wide2narrow_stream.sv
// Bench for wide2narrow_stream: directed cases plus random traffic on four parameter sets,
// every output beat checked against a slice-list reference model.
module tb_wide2narrow_stream;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wide2narrow_stream_if #(.NARROW_W(4), .RATIO(2)) b0 ();
  wide2narrow_stream_if #(.NARROW_W(8), .RATIO(4)) b1 ();
  wide2narrow_stream_if #(.NARROW_W(4), .RATIO(1)) b2 ();
  wide2narrow_stream_if #(.NARROW_W(4), .RATIO(3)) b3 ();

  wide2narrow_stream #(.NARROW_W(4), .RATIO(2), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  wide2narrow_stream #(.NARROW_W(8), .RATIO(4), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  wide2narrow_stream #(.NARROW_W(4), .RATIO(1), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  wide2narrow_stream #(.NARROW_W(4), .RATIO(3), .MSB_FIRST(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] d;
    logic        first;
    logic        last;
  } exp_t;

  exp_t        q[4][$];
  int          NW[4] = '{4, 8, 4, 4};
  int          RT[4] = '{2, 4, 1, 3};
  bit          MS[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          stall[4];
  logic [31:0] pd[4];
  logic        pf[4], pl[4];
  int          beats[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a word with count c yields min(c, RATIO-1)+1 slices in the configured order.
  task automatic push_word(input int id, input logic [31:0] d, input int cnt);
    int   k;
    int   idx;
    exp_t e;
    k = ((cnt > RT[id] - 1) ? RT[id] - 1 : cnt) + 1;
    for (int j = 0; j < k; j++) begin
      idx     = MS[id] ? RT[id] - 1 - j : j;
      e.d     = (d >> (idx * NW[id])) & ((32'd1 << NW[id]) - 32'd1);
      e.first = (j == 0);
      e.last  = (j == k - 1);
      q[id].push_back(e);
    end
  endtask

  task automatic mon(input int id, input logic sv, input logic sr, input logic [31:0] sd,
                     input logic [31:0] sc, input logic mv, input logic mr,
                     input logic [31:0] md, input logic mf, input logic ml);
    exp_t e;
    if (!rst_n) begin
      q[id].delete();
      stall[id] = 1'b0;
    end else begin
      if (stall[id]) begin
        chk($sformatf("u%0d_hold_valid", id), 64'(mv), 64'd1);
        chk($sformatf("u%0d_hold_beat", id), {30'b0, mf, ml, md}, {30'b0, pf[id], pl[id], pd[id]});
      end
      if (mv && mr) begin
        beats[id]++;
        chk($sformatf("u%0d_beat_expected", id), 64'(q[id].size() != 0), 64'd1);
        if (q[id].size() != 0) begin
          e = q[id].pop_front();
          chk($sformatf("u%0d_data", id), 64'(md), 64'(e.d));
          chk($sformatf("u%0d_first", id), 64'(mf), 64'(e.first));
          chk($sformatf("u%0d_last", id), 64'(ml), 64'(e.last));
        end
      end
      if (sv && sr) push_word(id, sd, int'(sc));
      stall[id] = mv && !mr;
      pd[id] = md; pf[id] = mf; pl[id] = ml;
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.s_valid, b0.s_ready, 32'(b0.s_data), 32'(b0.s_cnt), b0.m_valid, b0.m_ready, 32'(b0.m_data), b0.m_first, b0.m_last);
    mon(1, b1.s_valid, b1.s_ready, 32'(b1.s_data), 32'(b1.s_cnt), b1.m_valid, b1.m_ready, 32'(b1.m_data), b1.m_first, b1.m_last);
    mon(2, b2.s_valid, b2.s_ready, 32'(b2.s_data), 32'(b2.s_cnt), b2.m_valid, b2.m_ready, 32'(b2.m_data), b2.m_first, b2.m_last);
    mon(3, b3.s_valid, b3.s_ready, 32'(b3.s_data), 32'(b3.s_cnt), b3.m_valid, b3.m_ready, 32'(b3.m_data), b3.m_first, b3.m_last);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic exp0(input string tag, input logic v, input logic [3:0] d, input logic f, input logic l);
    chk({tag, "_valid"}, 64'(b0.m_valid), 64'(v));
    if (v) begin
      chk({tag, "_data"}, 64'(b0.m_data), 64'(d));
      chk({tag, "_first"}, 64'(b0.m_first), 64'(f));
      chk({tag, "_last"}, 64'(b0.m_last), 64'(l));
    end
  endtask

  logic [3:0] seq2;

  initial begin
    rst_n = 1'b0;
    b0.s_valid = 0; b0.s_data = '0; b0.s_cnt = '0; b0.m_ready = 0;
    b1.s_valid = 0; b1.s_data = '0; b1.s_cnt = '0; b1.m_ready = 0;
    b2.s_valid = 0; b2.s_data = '0; b2.s_cnt = '0; b2.m_ready = 0;
    b3.s_valid = 0; b3.s_data = '0; b3.s_cnt = '0; b3.m_ready = 0;
    step(); step(); smp();
    chk("rst_m_valid", 64'(b0.m_valid), 64'd0);
    chk("rst_m_data", 64'(b0.m_data), 64'd0);
    chk("rst_m_first_last", 64'({b0.m_first, b0.m_last}), 64'd0);
    chk("rst_u1_m_valid", 64'(b1.m_valid), 64'd0);
    step(); rst_n = 1'b1;
    smp();
    chk("idle_s_ready", 64'(b0.s_ready), 64'd1);

    // Test 1: basic two-slice word, MSB first.
    step(); b0.s_valid = 1; b0.s_data = 8'hA5; b0.s_cnt = 1'b1; b0.m_ready = 1;
    smp(); chk("t1_s_ready_idle", 64'(b0.s_ready), 64'd1);
    step(); b0.s_valid = 0;
    smp(); exp0("t1_s0", 1, 4'hA, 1, 0);
    chk("t1_s_ready_busy", 64'(b0.s_ready), 64'd0);
    step(); smp(); exp0("t1_s1", 1, 4'h5, 0, 1);
    step(); smp(); exp0("t1_done", 0, 4'h0, 0, 0);

    // Test 2: back-to-back words with no bubble.
    step(); b0.s_valid = 1; b0.s_data = 8'h12;
    smp(); step(); b0.s_data = 8'h34;
    smp(); exp0("t2_s0", 1, 4'h1, 1, 0);
    step(); smp(); exp0("t2_s1", 1, 4'h2, 0, 1);
    chk("t2_s_ready_last", 64'(b0.s_ready), 64'd1);
    step(); b0.s_valid = 0;
    smp(); exp0("t2_s2", 1, 4'h3, 1, 0);
    step(); smp(); exp0("t2_s3", 1, 4'h4, 0, 1);
    step(); smp(); exp0("t2_done", 0, 4'h0, 0, 0);

    // Test 3: downstream stall holds the first slice.
    step(); b0.s_valid = 1; b0.s_data = 8'hA5; b0.m_ready = 0;
    smp(); step(); b0.s_valid = 0;
    for (int i = 0; i < 3; i++) begin
      smp(); exp0($sformatf("t3_stall%0d", i), 1, 4'hA, 1, 0);
      step();
    end
    b0.m_ready = 1;
    smp(); exp0("t3_release", 1, 4'hA, 1, 0);
    step(); smp(); exp0("t3_s1", 1, 4'h5, 0, 1);
    step(); smp(); exp0("t3_done", 0, 4'h0, 0, 0);

    // Test 4: partial word, LSB first, wide lanes.
    step(); b1.s_valid = 1; b1.s_data = 32'h44332211; b1.s_cnt = 2'd2; b1.m_ready = 1;
    smp(); step(); b1.s_valid = 0;
    smp(); chk("t4_s0", {b1.m_valid, b1.m_first, b1.m_last, 53'b0, b1.m_data}, {3'b110, 53'b0, 8'h11});
    step(); smp(); chk("t4_s1", {b1.m_valid, b1.m_first, b1.m_last, 53'b0, b1.m_data}, {3'b100, 53'b0, 8'h22});
    step(); smp(); chk("t4_s2", {b1.m_valid, b1.m_first, b1.m_last, 53'b0, b1.m_data}, {3'b101, 53'b0, 8'h33});
    step(); smp(); chk("t4_no_4th", 64'(b1.m_valid), 64'd0);

    // Test 5: reset mid-word drops the rest; next word starts clean.
    step(); b0.s_valid = 1; b0.s_data = 8'hA5; b0.s_cnt = 1'b1;
    smp(); step(); b0.s_valid = 0; rst_n = 1'b0;
    #1 chk("t5_rst_m_valid", 64'(b0.m_valid), 64'd0);
    chk("t5_rst_m_data", 64'(b0.m_data), 64'd0);
    smp(); step(); rst_n = 1'b1;
    b0.s_valid = 1; b0.s_data = 8'hC3;
    smp(); step(); b0.s_valid = 0;
    smp(); exp0("t5_s0", 1, 4'hC, 1, 0);
    step(); smp(); exp0("t5_s1", 1, 4'h3, 0, 1);
    step();

    // Random traffic on all instances; RATIO=1 carries the 1..5 stream.
    beats[2] = 0;
    seq2 = 4'h1;
    for (int c = 0; c < 600; c++) begin
      b0.s_valid = 1'($urandom); b0.s_data = 8'($urandom);  b0.s_cnt = 1'($urandom); b0.m_ready = ($urandom_range(0, 3) != 0);
      b1.s_valid = 1'($urandom); b1.s_data = $urandom;      b1.s_cnt = 2'($urandom); b1.m_ready = ($urandom_range(0, 3) != 0);
      b3.s_valid = 1'($urandom); b3.s_data = 12'($urandom); b3.s_cnt = 2'($urandom); b3.m_ready = ($urandom_range(0, 3) != 0);
      b2.s_valid = (seq2 <= 4'h5) && ($urandom_range(0, 1) != 0);
      b2.s_data  = seq2;
      b2.s_cnt   = 1'($urandom);
      b2.m_ready = 1'($urandom);
      smp();
      if (b2.s_valid && b2.s_ready) seq2 = seq2 + 4'h1;
      step();
    end

    b0.s_valid = 0; b1.s_valid = 0; b2.s_valid = 0; b3.s_valid = 0;
    b0.m_ready = 1; b1.m_ready = 1; b2.m_ready = 1; b3.m_ready = 1;
    repeat (20) step();
    smp();
    for (int i = 0; i < 4; i++) chk($sformatf("u%0d_drained", i), 64'(q[i].size()), 64'd0);
    chk("u2_beats", 64'(beats[2]), 64'd5);
    chk("u2_idle", 64'(b2.m_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
